dmem_arbiter: RTL

Two-requester arbiter and sequencer for the shared data/instruction memory port of the NPC core. It accepts fetch requests (IFU) and load/store requests (LSU) over valid/ready handshakes and serialises them onto one memory port that uses req/gnt/rvalid signalling. For the LSU it also performs byte-lane formatting: store strobes and write-data shifting, and load extraction with sign or zero extension. It sits between the core front-end/LSU and the data memory model.

---
 rtl/dmem_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (IFU/LSU) arbiter and sequencer for the shared memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is LSU > IFU.
module dmem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_memop,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  lo;
  logic [2:0]  op;
  logic        we;
  logic        src_lsu;

  logic        pick_lsu;
  logic        pick_ifu;
  logic        take;
  logic        bad;
  logic        lsu_bad;
  logic [31:0] addr_n;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [7:0]  b8;
  logic [15:0] h16;
  logic [31:0] ld;

`ifdef MEM_ARB_RR_EN
  logic last_lsu;

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    pick_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
  end

  // Remember who was granted last; resets to LSU so IFU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu <= 1'b1;
    end else if (state == IDLE && take) begin
      last_lsu <= pick_lsu;
    end
  end
`else
  // Fixed priority: LSU always beats IFU.
  always_comb begin
    pick_lsu = lsu_req_valid;
  end
`endif

  assign pick_ifu      = ifu_req_valid && !pick_lsu;
  assign take          = pick_lsu || pick_ifu;
  assign lsu_req_ready = !rst && state == IDLE && pick_lsu;
  assign ifu_req_ready = !rst && state == IDLE && pick_ifu;
  assign addr_n        = pick_lsu ? lsu_addr : ifu_addr;
  assign bad           = pick_lsu ? lsu_bad : |ifu_addr[1:0];

  // Decode LSU size: alignment check, store strobes and lane replication.
  always_comb begin
    strb_n  = 4'b0000;
    wdata_n = 32'd0;
    lsu_bad = 1'b0;
    case (lsu_memop)
      3'b000, 3'b100: begin
        strb_n  = 4'b0001 << lsu_addr[1:0];
        wdata_n = {4{lsu_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        lsu_bad = lsu_addr[0];
        strb_n  = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{lsu_wdata[15:0]}};
      end
      3'b010: begin
        lsu_bad = |lsu_addr[1:0];
        strb_n  = 4'b1111;
        wdata_n = lsu_wdata;
      end
      default: lsu_bad = 1'b1;
    endcase
    if (!lsu_we) begin
      strb_n  = 4'b0000;
      wdata_n = 32'd0;
    end
  end

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    b8  = mem_rdata[{lo, 3'b000} +: 8];
    h16 = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op)
      3'b000:  ld = {{24{b8[7]}}, b8};
      3'b100:  ld = {24'd0, b8};
      3'b001:  ld = {{16{h16[15]}}, h16};
      3'b101:  ld = {16'd0, h16};
      default: ld = mem_rdata;
    endcase
  end

  // Main sequencer: accept, request, wait for data, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      lo             <= 2'b00;
      op             <= 3'b000;
      we             <= 1'b0;
      src_lsu        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 32'd0;
      mem_wstrb      <= 4'b0000;
      mem_wdata      <= 32'd0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= 32'd0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= 32'd0;
      lsu_resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            lo      <= addr_n[1:0];
            op      <= pick_lsu ? lsu_memop : 3'b010;
            we      <= pick_lsu && lsu_we;
            src_lsu <= pick_lsu;
            cnt     <= 16'd0;
            if (bad) begin
              state          <= RESP;
              ifu_resp_valid <= pick_ifu;
              ifu_resp_err   <= pick_ifu;
              lsu_resp_valid <= pick_lsu;
              lsu_resp_err   <= pick_lsu;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= pick_lsu && lsu_we;
              mem_addr  <= {addr_n[31:2], 2'b00};
              mem_wstrb <= pick_lsu ? strb_n : 4'b0000;
              mem_wdata <= pick_lsu ? wdata_n : 32'd0;
            end
          end
        end
        REQ: begin
          if (mem_gnt || cnt == TO_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'd0;
          end
          if (mem_gnt) begin
            state <= WAIT;
          end else if (cnt == TO_LAST) begin
            state          <= RESP;
            ifu_resp_valid <= !src_lsu;
            ifu_resp_err   <= !src_lsu;
            lsu_resp_valid <= src_lsu;
            lsu_resp_err   <= src_lsu;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= RESP;
            if (src_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= we ? 32'd0 : ld;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= mem_rdata;
            end
          end
        end
        RESP: begin
          state          <= IDLE;
          ifu_resp_valid <= 1'b0;
          ifu_rdata      <= 32'd0;
          ifu_resp_err   <= 1'b0;
          lsu_resp_valid <= 1'b0;
          lsu_rdata      <= 32'd0;
          lsu_resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
